// File: rtl/tc_rst_seq.sv
// ---------------------------------------------------------------------------
// tc_rst_seq
//
// Staged reset sequencer. After the lock-qualified generator reset (rsti)
// deasserts, all downstream resets are held for HOLD_CYC cycles. The stages
// are then released one at a time in index order. Each release waits for the
// previous stage's synchronized ready acknowledge. A stage that never comes
// up within TMO_CYC cycles, or that drops its ready once everything is
// running, latches a sticky fault. A soft_rst pulse restarts the whole
// sequence from any state.
//
// Ports
//   clk125    in   1       single clock for the block
//   rsti      in   1       asynchronous active-high reset
//   soft_rst  in   1       synchronous one-cycle restart pulse
//   stg_rdy   in   STAGES  per-stage ready acknowledges (may be asynchronous)
//   stg_rst   out  STAGES  per-stage active-high resets (registered)
//   all_rdy   out  1       every stage released and ready (registered)
//   err       out  1       sticky timeout/dropout fault (registered)
//   err_stg   out  3       faulting stage index, valid while err is high
// ---------------------------------------------------------------------------
module tc_rst_seq #(
    parameter int STAGES   = 4,
    parameter int HOLD_CYC = 1024,
    parameter int TMO_CYC  = 65536
) (
    input  logic              clk125,
    input  logic              rsti,
    input  logic              soft_rst,
    input  logic [STAGES-1:0] stg_rdy,
    output logic [STAGES-1:0] stg_rst,
    output logic              all_rdy,
    output logic              err,
    output logic [2:0]        err_stg
);

    localparam int HW = $clog2(HOLD_CYC);
    localparam int TW = $clog2(TMO_CYC);

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TMO_CYC - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(STAGES - 1);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // Lowest stage index whose ready is low; 0 when none is low.
    function automatic logic [2:0] first_zero(input logic [STAGES-1:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (!v[i]) begin
                r = 3'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    logic [STAGES-1:0] sync1_q;
    logic [STAGES-1:0] rdy_s_q;

    state_t            state_q,   state_d;
    logic [HW-1:0]     hold_q,    hold_d;
    logic [TW-1:0]     tmo_q,     tmo_d;
    logic [2:0]        idx_q,     idx_d;
    logic [2:0]        err_stg_q, err_stg_d;
    logic [STAGES-1:0] stg_rst_q, stg_rst_d;
    logic              all_rdy_q, all_rdy_d;
    logic              err_q,     err_d;

    logic [7:0]        rdy_pad_s;
    logic              rdy_cur_s;

    // Two-flop synchronizer for the possibly asynchronous ready inputs.
    always_ff @(posedge clk125 or posedge rsti) begin
        if (rsti) begin
            sync1_q <= '0;
            rdy_s_q <= '0;
        end else begin
            sync1_q <= stg_rdy;
            rdy_s_q <= sync1_q;
        end
    end

    // Widen the synchronized readies to eight bits so the 3-bit stage index
    // can select from them for any STAGES value.
    always_comb begin
        rdy_pad_s = 8'h00;
        for (int i = 0; i < STAGES; i++) begin
            rdy_pad_s[i] = rdy_s_q[i];
        end
        rdy_cur_s = rdy_pad_s[idx_q];
    end

    // FSM state and counter registers.
    always_ff @(posedge clk125 or posedge rsti) begin
        if (rsti) begin
            state_q   <= ST_HOLD;
            hold_q    <= '0;
            tmo_q     <= '0;
            idx_q     <= 3'd0;
            err_stg_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            tmo_q     <= tmo_d;
            idx_q     <= idx_d;
            err_stg_q <= err_stg_d;
        end
    end

    // Next-state logic. soft_rst overrides every other transition. In WAIT a
    // ready is checked before the timeout, so a ready arriving on the
    // terminal count still advances the sequence.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        tmo_d     = tmo_q;
        idx_d     = idx_q;
        err_stg_d = err_stg_q;
        if (soft_rst) begin
            state_d   = ST_HOLD;
            hold_d    = '0;
            tmo_d     = '0;
            idx_d     = 3'd0;
            err_stg_d = 3'd0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_WAIT;
                        hold_d  = '0;
                        idx_d   = 3'd0;
                        tmo_d   = '0;
                    end else begin
                        hold_d  = hold_q + HW'(1);
                    end
                end
                ST_WAIT: begin
                    if (rdy_cur_s) begin
                        tmo_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_RUN;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        state_d   = ST_FAULT;
                        tmo_d     = '0;
                        err_stg_d = idx_q;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
                ST_RUN: begin
                    // Earlier stages' readies are only re-checked here, not
                    // while later stages are still being brought up.
                    if (!(&rdy_s_q)) begin
                        state_d   = ST_FAULT;
                        err_stg_d = first_zero(rdy_s_q);
                    end else begin
                        state_d   = ST_RUN;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d   = ST_HOLD;
                    hold_d    = '0;
                    tmo_d     = '0;
                    idx_d     = 3'd0;
                    err_stg_d = 3'd0;
                end
            endcase
        end
    end

    // Output decode from the next state so the registered outputs change on
    // the same edge as the state they describe.
    always_comb begin
        stg_rst_d = '1;
        all_rdy_d = 1'b0;
        err_d     = 1'b0;
        case (state_d)
            ST_HOLD: begin
                stg_rst_d = '1;
            end
            ST_WAIT: begin
                for (int i = 0; i < STAGES; i++) begin
                    if (i <= int'(idx_d)) begin
                        stg_rst_d[i] = 1'b0;
                    end else begin
                        stg_rst_d[i] = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                stg_rst_d = '0;
                all_rdy_d = 1'b1;
            end
            ST_FAULT: begin
                stg_rst_d = '1;
                err_d     = 1'b1;
            end
            default: begin
                stg_rst_d = '1;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk125 or posedge rsti) begin
        if (rsti) begin
            stg_rst_q <= '1;
            all_rdy_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            stg_rst_q <= stg_rst_d;
            all_rdy_q <= all_rdy_d;
            err_q     <= err_d;
        end
    end

    assign stg_rst = stg_rst_q;
    assign all_rdy = all_rdy_q;
    assign err     = err_q;
    assign err_stg = err_stg_q;

endmodule

// File: tb/tb_tc_rst_seq.sv
// ---------------------------------------------------------------------------
// Directed testbench for tc_rst_seq with STAGES=4, HOLD_CYC=16, TMO_CYC=32.
// cyc counts clk125 edges since the most recent rsti release or step origin;
// inputs are driven and outputs sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_tc_rst_seq;

    logic       clk125;
    logic       rsti;
    logic       soft_rst;
    logic [3:0] stg_rdy;
    logic [3:0] stg_rst;
    logic       all_rdy;
    logic       err;
    logic [2:0] err_stg;

    int tests;
    int fails;
    int cyc;

    tc_rst_seq #(
        .STAGES   (4),
        .HOLD_CYC (16),
        .TMO_CYC  (32)
    ) dut (
        .clk125   (clk125),
        .rsti     (rsti),
        .soft_rst (soft_rst),
        .stg_rdy  (stg_rdy),
        .stg_rst  (stg_rst),
        .all_rdy  (all_rdy),
        .err      (err),
        .err_stg  (err_stg)
    );

    initial begin
        clk125 = 1'b0;
        forever #4 clk125 = ~clk125;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk125);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    initial begin
        logic [3:0] pre_v;
        logic [3:0] post_v;

        tests    = 0;
        fails    = 0;
        cyc      = 0;
        rsti     = 1'b1;
        soft_rst = 1'b0;
        stg_rdy  = 4'h0;

        // Reset state
        step();
        step();
        chk("rst_stg_rst", 32'(stg_rst), 32'hF);
        chk("rst_all_rdy", 32'(all_rdy), 32'h0);
        chk("rst_err",     32'(err),     32'h0);
        chk("rst_err_stg", 32'(err_stg), 32'h0);

        // Normal bring-up: ready 5 cycles after each release
        rsti = 1'b0;
        cyc  = 0;
        for (int k = 0; k < 4; k++) begin
            pre_v  = 4'hF << k;
            post_v = 4'hF << (k + 1);
            run_to(16 + 8 * k - 1);
            chk("bringup_pre", 32'(stg_rst), 32'(pre_v));
            run_to(16 + 8 * k);
            chk("bringup_rel", 32'(stg_rst), 32'(post_v));
            run_to(16 + 8 * k + 5);
            stg_rdy[k] = 1'b1;
        end
        run_to(47);
        chk("bringup_all_rdy_early", 32'(all_rdy), 32'h0);
        run_to(48);
        chk("bringup_all_rdy", 32'(all_rdy), 32'h1);
        chk("bringup_err",     32'(err),     32'h0);
        chk("bringup_stg_rst", 32'(stg_rst), 32'h0);

        // RUN dropout of stages 1 and 3 together
        run_to(50);
        stg_rdy = 4'b0101;
        run_to(52);
        chk("drop_err_early",  32'(err),     32'h0);
        chk("drop_rdy_early",  32'(all_rdy), 32'h1);
        run_to(53);
        chk("drop_err",        32'(err),     32'h1);
        chk("drop_err_stg",    32'(err_stg), 32'h1);
        chk("drop_stg_rst",    32'(stg_rst), 32'hF);
        chk("drop_all_rdy",    32'(all_rdy), 32'h0);

        // soft_rst out of FAULT
        run_to(55);
        stg_rdy  = 4'h0;
        soft_rst = 1'b1;
        step();
        soft_rst = 1'b0;
        chk("soft1_err",     32'(err),     32'h0);
        chk("soft1_err_stg", 32'(err_stg), 32'h0);
        chk("soft1_stg_rst", 32'(stg_rst), 32'hF);
        run_to(71);
        chk("soft1_hold",    32'(stg_rst), 32'hF);
        run_to(72);
        chk("soft1_rel0",    32'(stg_rst), 32'hE);

        // Timeout: stage 2 never readies (released at 88)
        run_to(77);
        stg_rdy[0] = 1'b1;
        run_to(80);
        chk("tmo_rel1",      32'(stg_rst), 32'hC);
        run_to(85);
        stg_rdy[1] = 1'b1;
        run_to(88);
        chk("tmo_rel2",      32'(stg_rst), 32'h8);
        run_to(119);
        chk("tmo_err_early", 32'(err),     32'h0);
        chk("tmo_wait_rst",  32'(stg_rst), 32'h8);
        run_to(120);
        chk("tmo_err",       32'(err),     32'h1);
        chk("tmo_err_stg",   32'(err_stg), 32'h2);
        chk("tmo_stg_rst",   32'(stg_rst), 32'hF);
        chk("tmo_all_rdy",   32'(all_rdy), 32'h0);

        // soft_rst out of the timeout fault
        run_to(121);
        stg_rdy  = 4'h0;
        soft_rst = 1'b1;
        step();
        soft_rst = 1'b0;
        chk("soft2_err",     32'(err),     32'h0);
        chk("soft2_err_stg", 32'(err_stg), 32'h0);
        chk("soft2_stg_rst", 32'(stg_rst), 32'hF);

        // Bring up to idx=2, then soft_rst mid-WAIT
        run_to(138);
        chk("soft2_rel0",    32'(stg_rst), 32'hE);
        run_to(143);
        stg_rdy[0] = 1'b1;
        run_to(151);
        stg_rdy[1] = 1'b1;
        run_to(154);
        chk("soft3_idx2",    32'(stg_rst), 32'h8);
        run_to(157);
        stg_rdy  = 4'h0;
        soft_rst = 1'b1;
        step();
        soft_rst = 1'b0;
        chk("soft3_stg_rst", 32'(stg_rst), 32'hF);
        chk("soft3_err",     32'(err),     32'h0);
        chk("soft3_all_rdy", 32'(all_rdy), 32'h0);
        run_to(173);
        chk("soft3_hold",    32'(stg_rst), 32'hF);
        run_to(174);
        chk("soft3_rel0",    32'(stg_rst), 32'hE);

        // Ready vs timeout collision: rdy_s[0] rises on the terminal count
        run_to(203);
        stg_rdy[0] = 1'b1;
        run_to(205);
        chk("coll_pre",      32'(stg_rst), 32'hE);
        chk("coll_err_pre",  32'(err),     32'h0);
        run_to(206);
        chk("coll_rel1",     32'(stg_rst), 32'hC);
        chk("coll_err",      32'(err),     32'h0);
        run_to(207);
        chk("coll_err_next", 32'(err),     32'h0);

        // Asynchronous reset between edges during WAIT
        run_to(208);
        #2;
        rsti = 1'b1;
        #1;
        chk("async_stg_rst", 32'(stg_rst), 32'hF);
        chk("async_all_rdy", 32'(all_rdy), 32'h0);
        chk("async_err",     32'(err),     32'h0);
        chk("async_err_stg", 32'(err_stg), 32'h0);

        // Early ready: all readies high before release
        stg_rdy = 4'hF;
        step();
        step();
        rsti = 1'b0;
        cyc  = 0;
        run_to(15);
        chk("early_hold",    32'(stg_rst), 32'hF);
        run_to(16);
        chk("early_rel0",    32'(stg_rst), 32'hE);
        run_to(17);
        chk("early_rel1",    32'(stg_rst), 32'hC);
        run_to(18);
        chk("early_rel2",    32'(stg_rst), 32'h8);
        run_to(19);
        chk("early_rel3",    32'(stg_rst), 32'h0);
        chk("early_rdy_pre", 32'(all_rdy), 32'h0);
        run_to(20);
        chk("early_all_rdy", 32'(all_rdy), 32'h1);
        chk("early_err",     32'(err),     32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
